// File: rtl/signal_analyzer.sv
// Per-record min/max/saturating-sum/count of ADC samples, framed by DDS phase wraps, with a one-entry output buffer.
// Optional SIGNAL_ANALYZER_OVERRUN_CNT_EN adds a saturating overrun_count output.
module signal_analyzer #(
    parameter int AXIS_TDATA_WIDTH       = 16,
    parameter int AXIS_TDATA_PHASE_WIDTH = 16,
    parameter int CFG_DATA_WIDTH         = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [AXIS_TDATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic [AXIS_TDATA_PHASE_WIDTH-1:0] s_axis_tdata_phase,
    input  logic                              s_axis_tvalid_phase,
    input  logic [CFG_DATA_WIDTH-1:0]         cfg_data,
    output logic [63:0]                       m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [31:0]                       sample_count,
    output logic                              overrun,
`ifdef SIGNAL_ANALYZER_OVERRUN_CNT_EN
    output logic [15:0]                       overrun_count,
`endif
    output logic [1:0]                        state_dbg
);

    // Output handshake: a record transfers on any cycle with m_axis_tvalid and
    // m_axis_tready both high; tdata/sample_count are held stable until then.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam logic signed [32:0] SUM_MAX = 33'sh0_7FFF_FFFF;
    localparam logic signed [32:0] SUM_MIN = 33'sh1_8000_0000;

    state_t state, state_next;

    logic                              enable;
    logic                              beat;
    logic                              wrap;
    logic                              first_beat;
    logic [AXIS_TDATA_PHASE_WIDTH-1:0] prev_phase;
    logic [7:0]                        nm1_r;
    logic [7:0]                        period_cnt;
    logic signed [AXIS_TDATA_WIDTH-1:0] sample;
    logic signed [AXIS_TDATA_WIDTH-1:0] min_r;
    logic signed [AXIS_TDATA_WIDTH-1:0] max_r;
    logic signed [31:0]                sum_r;
    logic signed [32:0]                sum_add;
    logic signed [31:0]                sum_sat;
    logic [31:0]                       cnt_r;
    logic                              start;
    logic                              close;
    logic                              accum_beat;
    logic                              drop;
    logic [63:0]                       rec_tdata;
    logic                              unused_cfg;

    function automatic logic [15:0] to16(input logic signed [AXIS_TDATA_WIDTH-1:0] v);
        logic signed [31:0] t;
        t = 32'(v);
        return t[15:0];
    endfunction

    assign enable     = cfg_data[0];
    assign unused_cfg = ^{cfg_data[CFG_DATA_WIDTH-1:16], cfg_data[7:1]};
    assign sample     = s_axis_tdata;
    assign beat       = s_axis_tvalid && s_axis_tvalid_phase;
    // The first beat after leaving IDLE only seeds prev_phase; its stale value is never compared.
    assign wrap       = beat && !first_beat && (s_axis_tdata_phase < prev_phase);

    assign start      = (state == ARM) && enable && wrap;
    assign close      = (state == ACCUM) && enable && wrap && (period_cnt == nm1_r);
    assign accum_beat = (state == ACCUM) && enable && beat;
    assign drop       = close && m_axis_tvalid && !m_axis_tready;

    assign sum_add   = 33'(sum_r) + 33'(sample);
    assign sum_sat   = (sum_add > SUM_MAX) ? 32'sh7FFF_FFFF :
                       (sum_add < SUM_MIN) ? 32'sh8000_0000 : sum_add[31:0];
    assign rec_tdata = {to16(max_r), to16(min_r), sum_r};
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = ARM;
            ARM:     if (!enable) state_next = IDLE;
                     else if (wrap) state_next = ACCUM;
            ACCUM:   if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            first_beat <= 1'b1;
            prev_phase <= '0;
            nm1_r      <= '0;
            period_cnt <= '0;
            min_r      <= '0;
            max_r      <= '0;
            sum_r      <= '0;
            cnt_r      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                first_beat <= 1'b1;
                nm1_r      <= cfg_data[15:8];
            end else if (beat) begin
                first_beat <= 1'b0;
                prev_phase <= s_axis_tdata_phase;
            end
            // A closing wrap beat opens the next record, so records tile with no gaps.
            if (start || close) begin
                sum_r      <= 32'(sample);
                min_r      <= sample;
                max_r      <= sample;
                cnt_r      <= 32'd1;
                period_cnt <= '0;
            end else if (accum_beat) begin
                sum_r <= sum_sat;
                if (sample < min_r) min_r <= sample;
                if (sample > max_r) max_r <= sample;
                if (cnt_r != 32'hFFFF_FFFF) cnt_r <= cnt_r + 32'd1;
                if (wrap) period_cnt <= period_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            sample_count  <= '0;
            overrun       <= 1'b0;
        end else if (close) begin
            if (drop) begin
                overrun <= 1'b1;
            end else begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= rec_tdata;
                sample_count  <= cnt_r;
            end
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef SIGNAL_ANALYZER_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (drop && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_signal_analyzer.sv
// Directed bench for signal_analyzer: a vector table of whole-record cases plus
// hand-written sequences for latency, saturation, backpressure, disable and gapped input.
module tb_signal_analyzer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [15:0] s_axis_tdata_phase;
    logic        s_axis_tvalid_phase;
    logic [63:0] cfg_data;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] sample_count;
    logic        overrun;
    logic [1:0]  state_dbg;
`ifdef SIGNAL_ANALYZER_OVERRUN_CNT_EN
    logic [15:0] overrun_count;
`endif

    signal_analyzer dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tdata_phase  (s_axis_tdata_phase),
        .s_axis_tvalid_phase (s_axis_tvalid_phase),
        .cfg_data            (cfg_data),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .sample_count        (sample_count),
        .overrun             (overrun),
`ifdef SIGNAL_ANALYZER_OVERRUN_CNT_EN
        .overrun_count       (overrun_count),
`endif
        .state_dbg           (state_dbg)
    );

    always #4 clk = ~clk;

    typedef struct {
        int base;
        int delta;
        int step;
        int nm1;
        int emax;
        int emin;
        int esum;
        int ecnt;
    } vec_t;

    vec_t        vecs[5];
    logic [95:0] acc_q[$];
    logic [95:0] exp_q[$];
    logic [15:0] ph;
    logic [15:0] step;
    int          n_checks = 0;
    int          n_errors = 0;

    // Accepted records, seen away from the active edge: {sample_count, tdata}.
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready)
            acc_q.push_back({sample_count, m_axis_tdata});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] rec(input int cnt, input int mx, input int mn, input int sm);
        return {32'(cnt), 16'(mx), 16'(mn), 32'(sm)};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        s_axis_tdata        = '0;
        s_axis_tvalid       = 1'b0;
        s_axis_tdata_phase  = '0;
        s_axis_tvalid_phase = 1'b0;
        cfg_data            = '0;
        m_axis_tready       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ph    = '0;
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic arm(input logic [7:0] nm1);
        cfg_data = {48'd0, nm1, 7'd0, 1'b1};
        tick();
    endtask

    task automatic beat_ph(input int s, input logic [15:0] p);
        s_axis_tdata        = 16'(s);
        s_axis_tdata_phase  = p;
        s_axis_tvalid       = 1'b1;
        s_axis_tvalid_phase = 1'b1;
        tick();
        s_axis_tvalid       = 1'b0;
        s_axis_tvalid_phase = 1'b0;
    endtask

    task automatic beat(input int s);
        beat_ph(s, ph);
        ph = ph + step;
    endtask

    task automatic cur(input string name, input logic [95:0] exp);
        check(name, {sample_count, m_axis_tdata}, exp);
    endtask

    initial begin
        vecs[0] = '{100,     0, 4096,  0,   100,    100,    1600, 16};
        vecs[1] = '{-50,    10, 4096,  0,   -20,    -50,    -560, 16};
        vecs[2] = '{7,      -3, 8192,  1,     7,     -2,      40, 16};
        vecs[3] = '{-32768,  0, 16384, 3, -32768, -32768, -524288, 16};
        vecs[4] = '{32767,   0, 4096,  3, 32767,  32767, 2097088, 64};

        // Reset state
        do_reset();
        check("rst_tvalid", 96'(m_axis_tvalid), 96'd0);
        cur("rst_rec", 96'd0);
        check("rst_overrun", 96'(overrun), 96'd0);
        check("rst_state", 96'(state_dbg), 96'd0);
`ifdef SIGNAL_ANALYZER_OVERRUN_CNT_EN
        check("rst_ovcnt", 96'(overrun_count), 96'd0);
`endif

        // Table: run to the first closing wrap, expect exactly one record
        for (int v = 0; v < 5; v++) begin
            int p;
            int n;
            do_reset();
            step = 16'(vecs[v].step);
            arm(8'(vecs[v].nm1));
            p = 65536 / vecs[v].step;
            n = vecs[v].nm1 + 1;
            for (int i = 0; i < p * (n + 1) + 1; i++)
                beat(vecs[v].base + (i % 4) * vecs[v].delta);
            tick();
            tick();
            exp_q.push_back(rec(vecs[v].ecnt, vecs[v].emax, vecs[v].emin, vecs[v].esum));
            check("vec_nrec", 96'(acc_q.size()), 96'd1);
            check("vec_rec", (acc_q.size() > 0) ? acc_q.pop_front() : 96'd0, exp_q.pop_front());
        end

        // Latency 1 and one record every 16 beats
        do_reset();
        step = 16'd4096;
        arm(8'd0);
        check("arm_state", 96'(state_dbg), 96'd1);
        for (int i = 0; i < 32; i++) beat(100);
        check("lat_before", 96'(m_axis_tvalid), 96'd0);
        beat(100);
        check("lat_valid", 96'(m_axis_tvalid), 96'd1);
        cur("lat_rec", rec(16, 100, 100, 1600));
        beat(100);
        check("lat_accepted", 96'(m_axis_tvalid), 96'd0);
        for (int i = 34; i < 48; i++) beat(100);
        check("lat_gap", 96'(m_axis_tvalid), 96'd0);
        beat(100);
        check("lat_second", 96'(m_axis_tvalid), 96'd1);
        cur("lat_rec2", rec(16, 100, 100, 1600));

        // Positive saturation: 70000 beats of +32767 in one record
        do_reset();
        arm(8'd0);
        beat_ph(32767, 16'd100);
        beat_ph(32767, 16'd0);
        for (int i = 1; i < 70000; i++) beat_ph(32767, (i > 65535) ? 16'hFFFF : 16'(i));
        check("sat_before", 96'(m_axis_tvalid), 96'd0);
        beat_ph(32767, 16'd0);
        check("sat_valid", 96'(m_axis_tvalid), 96'd1);
        cur("sat_rec", rec(70000, 32767, 32767, 32'h7FFF_FFFF));

        // Backpressure across two closes: hold first, drop second
        do_reset();
        m_axis_tready = 1'b0;
        step = 16'd4096;
        arm(8'd0);
        for (int i = 0; i < 32; i++) beat(100);
        beat(200);
        check("ovr_valid", 96'(m_axis_tvalid), 96'd1);
        cur("ovr_rec1", rec(16, 100, 100, 1600));
        for (int i = 33; i < 48; i++) beat(200);
        check("ovr_flag0", 96'(overrun), 96'd0);
        beat(300);
        cur("ovr_hold", rec(16, 100, 100, 1600));
        check("ovr_flag1", 96'(overrun), 96'd1);
`ifdef SIGNAL_ANALYZER_OVERRUN_CNT_EN
        check("ovr_count", 96'(overrun_count), 96'd1);
`endif
        m_axis_tready = 1'b1;
        beat(300);
        check("ovr_drain", 96'(m_axis_tvalid), 96'd0);
        check("ovr_acc_n", 96'(acc_q.size()), 96'd1);
        check("ovr_acc", (acc_q.size() > 0) ? acc_q.pop_front() : 96'd0, rec(16, 100, 100, 1600));
        for (int i = 50; i < 64; i++) beat(300);
        beat(400);
        m_axis_tready = 1'b0;
        cur("ovr_rec3", rec(16, 300, 300, 4800));
        check("ovr_sticky", 96'(overrun), 96'd1);
        // Reset with a record pending discards it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_pend_valid", 96'(m_axis_tvalid), 96'd0);
        check("rst_pend_ovr", 96'(overrun), 96'd0);
        cur("rst_pend_rec", 96'd0);

        // Accept in the same cycle the next record closes
        do_reset();
        m_axis_tready = 1'b0;
        step = 16'd4096;
        arm(8'd0);
        for (int i = 0; i < 32; i++) beat(100);
        for (int i = 32; i < 48; i++) beat(200);
        m_axis_tready = 1'b1;
        beat(300);
        m_axis_tready = 1'b0;
        check("same_valid", 96'(m_axis_tvalid), 96'd1);
        cur("same_rec2", rec(16, 200, 200, 3200));
        check("same_ovr", 96'(overrun), 96'd0);
        check("same_acc", (acc_q.size() > 0) ? acc_q.pop_front() : 96'd0, rec(16, 100, 100, 1600));

        // Disable mid-ACCUM, re-arm; NM1 changes while running are ignored
        do_reset();
        step = 16'd4096;
        arm(8'd0);
        for (int i = 0; i < 26; i++) beat(5);
        cfg_data[0] = 1'b0;
        beat(5);
        tick();
        check("dis_state", 96'(state_dbg), 96'd0);
        ph = '0;
        arm(8'd0);
        cfg_data = {48'd0, 8'd3, 7'd0, 1'b1};
        for (int i = 0; i < 32; i++) beat(5);
        check("dis_none", 96'(acc_q.size()), 96'd0);
        beat(5);
        check("dis_valid", 96'(m_axis_tvalid), 96'd1);
        cur("dis_rec", rec(16, 5, 5, 80));

        // Gapped input: only true beats count, junk cycles ignored
        do_reset();
        step = 16'd4096;
        arm(8'd1);
        for (int i = 0; i < 48; i++) begin
            beat(10);
            s_axis_tdata        = 16'd30000;
            s_axis_tdata_phase  = '0;
            s_axis_tvalid       = (i % 2 == 0);
            s_axis_tvalid_phase = (i % 2 != 0);
            tick();
        end
        check("gap_before", 96'(m_axis_tvalid), 96'd0);
        beat(10);
        check("gap_valid", 96'(m_axis_tvalid), 96'd1);
        cur("gap_rec", rec(32, 10, 10, 320));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
